// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch debouncer.
// Build option SW_DEBOUNCE_GLITCH_CNT_EN adds the rejected-glitch counter.
package sw_debounce_pkg;

  localparam int SW_DEBOUNCE_WIDTH        = 16;
  localparam int SW_DEBOUNCE_TICK_DIV     = 1000;
  localparam int SW_DEBOUNCE_STABLE_TICKS = 4;
  localparam int SW_DEBOUNCE_SYNC_STAGES  = 2;

  localparam logic [15:0] GLITCH_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter and debounced output flop.
// The glitch output exists only when SW_DEBOUNCE_GLITCH_CNT_EN is defined.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = SW_DEBOUNCE_SYNC_STAGES,
  parameter int STABLE_TICKS = SW_DEBOUNCE_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic tick,
  output logic dout,
  output logic flip
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic glitch
`endif
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   glitch_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // A disagreement must survive STABLE_TICKS consecutive ticks to be accepted.
  always_comb begin
    cnt_d    = cnt_q;
    out_d    = out_q;
    glitch_d = 1'b0;
    if (sync == out_q) begin
      cnt_d    = '0;
      glitch_d = (cnt_q != '0);
    end else if (tick && (cnt_q == CNT_LAST)) begin
      out_d = sync;
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign dout = out_q;
  assign flip = out_d ^ out_q;

`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
  assign glitch = glitch_d;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_d;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Switch bus synchroniser/debouncer with a shared sample prescaler and change strobe.
// Defining SW_DEBOUNCE_GLITCH_CNT_EN adds the saturating glitch_cnt output.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH        = SW_DEBOUNCE_WIDTH,
  parameter int SYNC_STAGES  = SW_DEBOUNCE_SYNC_STAGES,
  parameter int TICK_DIV     = SW_DEBOUNCE_TICK_DIV,
  parameter int STABLE_TICKS = SW_DEBOUNCE_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             changed
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [15:0]      glitch_cnt
`endif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic             changed_q;
  logic [WIDTH-1:0] flip_w;
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
  logic [WIDTH-1:0] glitch_w;
  logic [15:0]      glitch_cnt_q;
`endif

  // Free-running prescaler; input activity never realigns it.
  assign tick  = (pre_q == TICK_LAST);
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .din   (in[g]),
      .tick  (tick),
      .dout  (out[g]),
      .flip  (flip_w[g])
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch(glitch_w[g])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      changed_q <= |flip_w;
    end
  end

  assign changed = changed_q;

`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt_q <= '0;
    end else if ((|glitch_w) && (glitch_cnt_q != GLITCH_CNT_MAX)) begin
      glitch_cnt_q <= glitch_cnt_q + 16'd1;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Randomised and directed bench for sw_debounce against a cycle-level reference model.
// Glitch counter checks are active when SW_DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_sw_debounce;

  localparam int W     = 16;
  localparam int SYNC  = 2;
  localparam int TDIV  = 4;
  localparam int STAB  = 3;

  logic          clk = 1'b0;
  logic          rst_s = 1'b1;
  logic [W-1:0]  in_s = '0;
  logic [W-1:0]  out_w;
  logic          chg_w;
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
  logic [15:0]   gcnt_w;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sw_debounce #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC),
    .TICK_DIV    (TDIV),
    .STABLE_TICKS(STAB)
  ) dut (
    .clk       (clk),
    .rst       (rst_s),
    .in        (in_s),
    .out       (out_w),
    .changed   (chg_w)
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(gcnt_w)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sync is the input delayed SYNC cycles, ticks every TDIV cycles,
  // a bit is accepted after STAB consecutive ticks of disagreement.
  logic [W-1:0] m_pipe[$];
  int           m_pre = 0;
  int           m_cnt[W];
  logic [W-1:0] m_out = '0;
  logic         m_chg = 1'b0;
  int           m_gl  = 0;

  task automatic model_step();
    logic [W-1:0] sync, nxt;
    bit tick, anyg;
    if (rst_s) begin
      m_pipe.delete();
      repeat (SYNC) m_pipe.push_back('0);
      m_pre = 0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
      m_out = '0;
      m_chg = 1'b0;
      m_gl  = 0;
    end else begin
      sync = m_pipe[$];
      tick = (m_pre == TDIV - 1);
      nxt  = m_out;
      anyg = 0;
      for (int i = 0; i < W; i++) begin
        if (sync[i] == m_out[i]) begin
          if (m_cnt[i] != 0) anyg = 1;
          m_cnt[i] = 0;
        end else if (tick) begin
          m_cnt[i]++;
          if (m_cnt[i] == STAB) begin
            nxt[i]   = sync[i];
            m_cnt[i] = 0;
          end
        end
      end
      m_chg = (nxt != m_out);
      m_out = nxt;
      if (anyg && m_gl < 65535) m_gl++;
      m_pre = (m_pre + 1) % TDIV;
      m_pipe.push_front(in_s);
      void'(m_pipe.pop_back());
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("out", 32'(out_w), 32'(m_out));
    check("changed", 32'(chg_w), 32'(m_chg));
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    check("glitch_cnt", 32'(gcnt_w), 32'(m_gl));
`endif
  endtask

  // Runs maxc cycles, reporting when out first equals target and how many strobes were seen.
  task automatic run_until(input logic [W-1:0] target, input int maxc,
                           output int lat, output int npulse, output logic chg_at);
    lat = -1;
    npulse = 0;
    chg_at = 1'b0;
    for (int n = 1; n <= maxc; n++) begin
      cycle();
      if (chg_w) npulse++;
      if (lat < 0 && out_w == target) begin
        lat = n;
        chg_at = chg_w;
      end
    end
  endtask

  int   lat, npulse;
  logic chg_at;
  int   g0;
  int   q;
  bit   par;
  int   hold;

  initial begin
    // Reset with all switches high
    rst_s = 1'b1;
    in_s  = 16'hFFFF;
    repeat (3) begin
      cycle();
      check("rst_out", 32'(out_w), 32'h0);
      check("rst_changed", 32'(chg_w), 32'h0);
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
      check("rst_glitch", 32'(gcnt_w), 32'h0);
`endif
    end
    rst_s = 1'b0;
    repeat (10) begin
      cycle();
      check("post_rst_out", 32'(out_w), 32'h0);
    end
    in_s = '0;
    repeat (20) cycle();

    // Clean step
    in_s = 16'h00A5;
    run_until(16'h00A5, 20, lat, npulse, chg_at);
    check("step_lat_ok", 32'(lat >= 11 && lat <= 15), 32'h1);
    check("step_pulses", 32'(npulse), 32'h1);
    check("step_chg_coincident", 32'(chg_at), 32'h1);
    in_s = '0;
    repeat (20) cycle();
    check("settle_zero", 32'(out_w), 32'h0);

    // Glitches on bit 0
    in_s = 16'h0001;
    repeat (3) cycle();
    in_s = '0;
    repeat (12) cycle();
    check("glitch3_out", 32'(out_w), 32'h0);
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    g0 = int'(gcnt_w);
`endif
    in_s = 16'h0001;
    repeat (7) cycle();
    in_s = '0;
    repeat (12) cycle();
    check("glitch7_out", 32'(out_w), 32'h0);
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    check("glitch7_inc", 32'(gcnt_w), 32'(g0 + 1));
`endif

    // Simultaneous flip of all bits
    in_s = 16'h00FF;
    repeat (20) cycle();
    check("pre_flip_out", 32'(out_w), 32'h00FF);
    in_s = 16'hFF00;
    run_until(16'hFF00, 20, lat, npulse, chg_at);
    check("flip_lat_ok", 32'(lat >= 11 && lat <= 15), 32'h1);
    check("flip_pulses", 32'(npulse), 32'h1);
    check("flip_chg_coincident", 32'(chg_at), 32'h1);

    // Reset mid-acceptance
    in_s = '0;
    repeat (20) cycle();
    in_s = 16'h0001;
    repeat (6) cycle();
    rst_s = 1'b1;
    cycle();
    check("midrst_out", 32'(out_w), 32'h0);
    rst_s = 1'b0;
    run_until(16'h0001, 20, lat, npulse, chg_at);
    check("midrst_lat_ok", 32'(lat >= 11 && lat <= 15), 32'h1);
    check("midrst_pulses", 32'(npulse), 32'h1);

    // Random bursts
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 2))
        0: in_s = 16'($urandom);
        1: in_s = in_s ^ 16'($urandom & $urandom);
        default: in_s = '0;
      endcase
      hold = $urandom_range(1, 14);
      repeat (hold) cycle();
    end
    in_s = '0;
    repeat (30) cycle();
    check("rand_settle", 32'(out_w), 32'h0);

`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    // One glitch event per cycle, staggered across five bits, until saturation
    par = 1'b0;
    for (int k = 0; k < 65600; k++) begin
      q = (m_pre + 2) % TDIV;
      if (q == TDIV - 1) par = ~par;
      in_s = '0;
      in_s[0] = (q == 3);
      in_s[1] = (q == 3) || (q == 0);
      in_s[2] = (q != 2);
      in_s[3] = par;
      in_s[4] = ~par;
      cycle();
    end
    check("sat_value", 32'(gcnt_w), 32'hFFFF);
    repeat (16) begin
      q = (m_pre + 2) % TDIV;
      if (q == TDIV - 1) par = ~par;
      in_s = '0;
      in_s[0] = (q == 3);
      in_s[3] = par;
      cycle();
    end
    check("sat_hold", 32'(gcnt_w), 32'hFFFF);
    check("sat_out", 32'(out_w), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
